// File: rtl/ts4231_multi_configurator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ts4231_multi_configurator                              |
// | Description : Brings up to CHANNELS TS4231 sensors into watch mode,  |
// |               one channel at a time, with write/readback verify,     |
// |               bounded retries and a light-pulse timeout.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ts4231_multi_configurator #(
  parameter int          CHANNELS      = 4,
  parameter int          CLK_DIV       = 96,
  parameter logic [15:0] CFG_WORD      = 16'h7256,
  parameter int          START_WAIT    = 5,
  parameter int          PULSE_TIMEOUT = 65535,
  parameter int          MAX_RETRIES   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reconfigure,
  input  logic [CHANNELS-1:0] chan_mask,
  output logic                busy,
  output logic [CHANNELS-1:0] configured,
  output logic [CHANNELS-1:0] failed,
  input  logic [CHANNELS-1:0] d_in,
  output logic [CHANNELS-1:0] d_out,
  output logic [CHANNELS-1:0] d_oe,
  input  logic [CHANNELS-1:0] e_in,
  output logic [CHANNELS-1:0] e_out,
  output logic [CHANNELS-1:0] e_oe
);

  localparam int c_DIV_W   = $clog2(CLK_DIV);
  localparam int c_CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_CNT_MAX = (PULSE_TIMEOUT > START_WAIT) ? PULSE_TIMEOUT : START_WAIT;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_RTY_W   = $clog2(MAX_RETRIES + 2);

  localparam logic [3:0] c_ST_IDLE        = 4'd0;
  localparam logic [3:0] c_ST_SELECT      = 4'd1;
  localparam logic [3:0] c_ST_WAIT_PULSE  = 4'd2;
  localparam logic [3:0] c_ST_START_CFG   = 4'd3;
  localparam logic [3:0] c_ST_WR_START    = 4'd4;
  localparam logic [3:0] c_ST_WR_E_LOW    = 4'd5;
  localparam logic [3:0] c_ST_WR_BIT      = 4'd6;
  localparam logic [3:0] c_ST_WR_E_HIGH   = 4'd7;
  localparam logic [3:0] c_ST_WR_STOP     = 4'd8;
  localparam logic [3:0] c_ST_RD_START    = 4'd9;
  localparam logic [3:0] c_ST_RD_E_LOW    = 4'd10;
  localparam logic [3:0] c_ST_RD_E_HIGH   = 4'd11;
  localparam logic [3:0] c_ST_RD_STOP     = 4'd12;
  localparam logic [3:0] c_ST_WATCH_ELOW  = 4'd13;
  localparam logic [3:0] c_ST_WATCH_DLOW  = 4'd14;
  localparam logic [3:0] c_ST_WATCH_EHIGH = 4'd15;

  logic [c_DIV_W-1:0]  r_div;
  logic                w_tick;
  logic                r_reconf_d;
  logic [CHANNELS-1:0] r_d_s1, r_d_s2;
  logic                w_din, w_start;
  logic                w_unused_e_in;

  logic [3:0]          r_state, w_state_nxt;
  logic [c_CH_W-1:0]   r_chan, w_chan_nxt, w_sel_idx;
  logic                w_sel_found;
  logic [CHANNELS-1:0] r_pend, w_pend_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [3:0]          r_bit, w_bit_nxt;
  logic [c_RTY_W-1:0]  r_retry, w_retry_nxt;
  logic [15:0]         r_shift, w_shift_nxt;
  logic                r_dprev, w_dprev_nxt;
  logic                r_busy, w_busy_nxt;
  logic [CHANNELS-1:0] r_cfg, w_cfg_nxt, r_fail, w_fail_nxt;

  logic                w_e, w_eoe, w_d, w_doe;
  logic [CHANNELS-1:0] w_e_out, w_e_oe, w_d_out, w_d_oe;
  logic [CHANNELS-1:0] r_e_out, r_e_oe, r_d_out, r_d_oe;

  assign w_tick        = (r_div == c_DIV_W'(CLK_DIV - 1));
  assign w_din         = r_d_s2[r_chan];
  assign w_start       = reconfigure & ~r_reconf_d & ~r_busy & (r_state == c_ST_IDLE);
  assign w_unused_e_in = ^e_in;

  // Free-running divider producing the one-clk protocol tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + c_DIV_W'(1);
  end

  // Reconfigure edge history and two-flop synchronisers on the D pads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reconf_d <= 1'b0;
      r_d_s1     <= '0;
      r_d_s2     <= '0;
    end else begin
      r_reconf_d <= reconfigure;
      r_d_s1     <= d_in;
      r_d_s2     <= r_d_s1;
    end
  end

  // State register together with the per-channel datapath and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_chan  <= '0;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_retry <= '0;
      r_shift <= '0;
      r_dprev <= 1'b0;
      r_busy  <= 1'b0;
      r_cfg   <= '0;
      r_fail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chan  <= w_chan_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_retry <= w_retry_nxt;
      r_shift <= w_shift_nxt;
      r_dprev <= w_dprev_nxt;
      r_busy  <= w_busy_nxt;
      r_cfg   <= w_cfg_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  // Next-state logic: start is taken at clk rate, everything else on tick
  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_retry_nxt = r_retry;
    w_shift_nxt = r_shift;
    w_dprev_nxt = r_dprev;
    w_busy_nxt  = r_busy;
    w_cfg_nxt   = r_cfg;
    w_fail_nxt  = r_fail;
    w_sel_idx   = '0;
    w_sel_found = 1'b0;
    // lowest pending channel wins
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel_idx   = c_CH_W'(i);
        w_sel_found = 1'b1;
      end
    end
    if (w_start) begin
      w_state_nxt = c_ST_SELECT;
      w_pend_nxt  = chan_mask;
      w_busy_nxt  = 1'b1;
      w_cfg_nxt   = r_cfg & ~chan_mask;
      w_fail_nxt  = r_fail & ~chan_mask;
    end else if (w_tick) begin
      case (r_state)
        c_ST_SELECT: begin
          if (w_sel_found) begin
            w_chan_nxt            = w_sel_idx;
            w_pend_nxt[w_sel_idx] = 1'b0;
            w_cnt_nxt             = '0;
            w_bit_nxt             = '0;
            w_retry_nxt           = '0;
            w_shift_nxt           = '0;
            w_dprev_nxt           = 1'b0;
            w_state_nxt           = c_ST_WAIT_PULSE;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = c_ST_IDLE;
          end
        end
        c_ST_WAIT_PULSE: begin
          w_dprev_nxt = w_din;
          if (r_dprev && !w_din) begin
            w_cnt_nxt   = '0;
            w_state_nxt = c_ST_START_CFG;
          end else if (r_cnt == c_CNT_W'(PULSE_TIMEOUT - 1)) begin
            w_fail_nxt[r_chan] = 1'b1;
            w_state_nxt        = c_ST_SELECT;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
          end
        end
        c_ST_START_CFG: begin
          if (r_cnt == c_CNT_W'(START_WAIT - 1)) w_state_nxt = c_ST_WR_START;
          else                                   w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        end
        c_ST_WR_START: w_state_nxt = c_ST_WR_E_LOW;
        c_ST_WR_E_LOW: w_state_nxt = c_ST_WR_BIT;
        c_ST_WR_BIT:   w_state_nxt = c_ST_WR_E_HIGH;
        c_ST_WR_E_HIGH: begin
          // 4-bit counter wraps back to 0 after the last bit
          w_bit_nxt   = r_bit + 4'd1;
          w_state_nxt = (r_bit == 4'd15) ? c_ST_WR_STOP : c_ST_WR_E_LOW;
        end
        c_ST_WR_STOP:  w_state_nxt = c_ST_RD_START;
        c_ST_RD_START: w_state_nxt = c_ST_RD_E_LOW;
        c_ST_RD_E_LOW: w_state_nxt = c_ST_RD_E_HIGH;
        c_ST_RD_E_HIGH: begin
          w_shift_nxt = {r_shift[14:0], w_din};
          w_bit_nxt   = r_bit + 4'd1;
          w_state_nxt = (r_bit == 4'd15) ? c_ST_RD_STOP : c_ST_RD_E_LOW;
        end
        c_ST_RD_STOP: begin
          // verify takes no tick of its own
          if (r_shift == CFG_WORD) begin
            w_state_nxt = c_ST_WATCH_ELOW;
          end else if (r_retry < c_RTY_W'(MAX_RETRIES)) begin
            w_retry_nxt = r_retry + c_RTY_W'(1);
            w_shift_nxt = '0;
            w_bit_nxt   = '0;
            w_state_nxt = c_ST_WR_START;
          end else begin
            w_fail_nxt[r_chan] = 1'b1;
            w_state_nxt        = c_ST_SELECT;
          end
        end
        c_ST_WATCH_ELOW: w_state_nxt = c_ST_WATCH_DLOW;
        c_ST_WATCH_DLOW: w_state_nxt = c_ST_WATCH_EHIGH;
        c_ST_WATCH_EHIGH: begin
          w_cfg_nxt[r_chan] = 1'b1;
          w_state_nxt       = c_ST_SELECT;
        end
        default: w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  // Pad drive decoded from the upcoming state so pads change with the state
  always_comb begin
    w_e   = 1'b1;
    w_eoe = 1'b0;
    w_d   = 1'b0;
    w_doe = 1'b0;
    case (w_state_nxt)
      c_ST_START_CFG: begin
        w_eoe = (w_cnt_nxt == c_CNT_W'(START_WAIT - 1));
      end
      c_ST_WR_START:                begin w_eoe = 1'b1; w_doe = 1'b1; end
      c_ST_WR_E_LOW, c_ST_WR_BIT:   begin w_eoe = 1'b1; w_doe = 1'b1; w_e = 1'b0;
                                          w_d = CFG_WORD[4'd15 - w_bit_nxt]; end
      c_ST_WR_E_HIGH:               begin w_eoe = 1'b1; w_doe = 1'b1;
                                          w_d = CFG_WORD[4'd15 - w_bit_nxt]; end
      c_ST_WR_STOP, c_ST_RD_STOP:   begin w_eoe = 1'b1; w_doe = 1'b1; w_d = 1'b1; end
      c_ST_RD_START:                begin w_eoe = 1'b1; w_doe = 1'b1; end
      c_ST_RD_E_LOW:                begin w_eoe = 1'b1; w_e = 1'b0; end
      c_ST_RD_E_HIGH:               begin w_eoe = 1'b1; end
      c_ST_WATCH_ELOW:              begin w_eoe = 1'b1; w_doe = 1'b1; w_e = 1'b0; w_d = 1'b1; end
      c_ST_WATCH_DLOW:              begin w_eoe = 1'b1; w_doe = 1'b1; w_e = 1'b0; end
      c_ST_WATCH_EHIGH:             begin w_eoe = 1'b1; w_doe = 1'b1; end
      default:                      begin w_eoe = 1'b0; end
    endcase
    w_e_out             = '1;
    w_e_oe              = '0;
    w_d_out             = '0;
    w_d_oe              = '0;
    w_e_out[w_chan_nxt] = w_e;
    w_e_oe[w_chan_nxt]  = w_eoe;
    w_d_out[w_chan_nxt] = w_d;
    w_d_oe[w_chan_nxt]  = w_doe;
  end

  // Registered pad outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_out <= '1;
      r_e_oe  <= '0;
      r_d_out <= '0;
      r_d_oe  <= '0;
    end else begin
      r_e_out <= w_e_out;
      r_e_oe  <= w_e_oe;
      r_d_out <= w_d_out;
      r_d_oe  <= w_d_oe;
    end
  end

  assign busy       = r_busy;
  assign configured = r_cfg;
  assign failed     = r_fail;
  assign e_out      = r_e_out;
  assign e_oe       = r_e_oe;
  assign d_out      = r_d_out;
  assign d_oe       = r_d_oe;

endmodule
`default_nettype wire
